mem_fifo_sched: RTL and testbench

// - Shares one memory_core (FIFO mode) between two write requesters (ch0 = original stream, ch1 = duplicate stream).
// - Round-robin arbitrates writes into the core and tracks core occupancy, because the core's full/empty are unused.
// - Issues reads under output credit, records the source id of every entry and tags returned data with it.
// - Sequences a drain-then-flush of the core on request.

---
 rtl/mem_fifo_sched_pkg.sv | 23 ++
 rtl/mem_fifo_sched_if.sv | 39 +++
 rtl/mem_fifo_sched_skid.sv | 59 +++++
 rtl/mem_fifo_sched.sv | 182 ++++++++++++++++++
 tb/tb_mem_fifo_sched.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_fifo_sched_pkg.sv
// mem_fifo_sched shared types and defaults.
// State encoding, default geometry, width helper.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FLUSH
  } sched_state_e;

  localparam int DW_D     = 16;
  localparam int DEPTH_D  = 64;
  localparam int RD_LAT_D = 1;
  localparam int OBUF_D   = 4;

  localparam int OCC_W = $clog2(DEPTH_D) + 1;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_fifo_sched_if.sv
// mem_fifo_sched requester/consumer bundle.
// master = traffic source/sink, slave = scheduler.
interface mem_fifo_sched_if #(
  parameter int DW = 16
);

  logic [1:0]    in_valid;
  logic [DW-1:0] in_data0;
  logic [DW-1:0] in_data1;
  logic [1:0]    in_ready;

  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;

  modport master (
    output in_valid,
    output in_data0,
    output in_data1,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  modport slave (
    input  in_valid,
    input  in_data0,
    input  in_data1,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface

// File: rtl/mem_fifo_sched_skid.sv
// Small circular FIFO used as the output skid buffer.
// Head is read combinationally; push while full is dropped.
module sched_skid_fifo
  import mem_sched_pkg::*;
#(
  parameter int W = 17,
  parameter int D = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                pop,
  output logic                head_valid,
  output logic [W-1:0]        head_data,
  output logic [cnt_w(D)-1:0] count
);

  localparam int AW  = (D > 1) ? $clog2(D) : 1;
  localparam int CNW = cnt_w(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign head_valid = count != '0;
  assign head_data  = mem[rptr];
  assign do_push    = push && (count != CNW'(D));
  assign do_pop     = pop && head_valid;

  // Entry storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Read/write pointers and fill level
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= (wptr == AW'(D - 1)) ? '0 : wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= (rptr == AW'(D - 1)) ? '0 : rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNW'(1);
        2'b01:   count <= count - CNW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_fifo_sched.sv
// Two-channel write scheduler in front of a FIFO memory core.
// Tracks occupancy, tags reads with source id, drains and flushes.
module mem_fifo_sched
  import mem_sched_pkg::*;
#(
  parameter int DW     = DW_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int RD_LAT = RD_LAT_D,
  parameter int OBUF   = OBUF_D
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_fifo_sched_if.slave        bus,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   core_wen,
  output logic [DW-1:0]          core_wdata,
  output logic                   core_ren,
  output logic                   core_flush,
  input  logic [DW-1:0]          core_rdata,
  input  logic                   core_rvalid,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   almost_full
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = AW + 1;
  localparam int CW  = cnt_w(OBUF + RD_LAT);
  localparam int OBW = cnt_w(OBUF);

  sched_state_e state;
  sched_state_e state_n;

  logic          rr;
  logic          wr_ok;
  logic [1:0]    grant;
  logic          gnt_src;
  logic          tag_clr;

  logic          tag_mem [DEPTH];
  logic [AW-1:0] tag_wp;
  logic [AW-1:0] tag_rp;

  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_t;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     used;

  logic           ob_push;
  logic           ob_pop;
  logic           ob_valid;
  logic [DW:0]    ob_head;
  logic [OBW-1:0] ob_cnt;

  // Next state and flush strobes
  always_comb begin
    state_n    = state;
    core_flush = 1'b0;
    flush_done = 1'b0;
    tag_clr    = 1'b0;
    unique case (state)
      RUN: begin
        if (flush_req) state_n = DRAIN;
      end
      DRAIN: begin
        if (occupancy == '0 && inflight == '0 &&
            ob_cnt == '0) begin
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        core_flush = 1'b1;
        flush_done = 1'b1;
        tag_clr    = 1'b1;
        state_n    = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign wr_ok = !reset && state == RUN &&
                 occupancy < OW'(DEPTH);

  // Round-robin write grant
  always_comb begin
    grant = 2'b00;
    if (wr_ok) begin
      case (bus.in_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign bus.in_ready = grant;
  assign core_wen     = |(bus.in_valid & grant);
  assign gnt_src      = grant[1];
  assign core_wdata   = grant[1] ? bus.in_data1 :
                        grant[0] ? bus.in_data0 : '0;

  // Reads already committed to the output buffer
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_v[i]);
    end
  end

  assign used     = CW'(ob_cnt) + inflight;
  assign core_ren = !reset && occupancy != '0 &&
                    used < CW'(OBUF);

  assign almost_full = occupancy >= OW'(DEPTH - 2);

  // State, pointer, occupancy and tag pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      rr        <= 1'b0;
      occupancy <= '0;
      tag_wp    <= '0;
      tag_rp    <= '0;
      pipe_v    <= '0;
      pipe_t    <= '0;
    end else begin
      state <= state_n;
      if (core_wen) rr <= ~gnt_src;
      case ({core_wen, core_ren})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
      if (tag_clr) begin
        tag_wp <= '0;
        tag_rp <= '0;
      end else begin
        if (core_wen) tag_wp <= tag_wp + AW'(1);
        if (core_ren) tag_rp <= tag_rp + AW'(1);
      end
      pipe_v[0] <= core_ren;
      pipe_t[0] <= tag_mem[tag_rp];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_t[i] <= pipe_t[i-1];
      end
    end
  end

  // Source id of every word written to the core
  always_ff @(posedge clk) begin
    if (core_wen) tag_mem[tag_wp] <= gnt_src;
  end

  assign ob_push = core_rvalid && pipe_v[RD_LAT-1];
  assign ob_pop  = ob_valid && bus.out_ready;

  sched_skid_fifo #(
    .W (DW + 1),
    .D (OBUF)
  ) u_obuf (
    .clk        (clk),
    .reset      (reset),
    .push       (ob_push),
    .push_data  ({pipe_t[RD_LAT-1], core_rdata}),
    .pop        (ob_pop),
    .head_valid (ob_valid),
    .head_data  (ob_head),
    .count      (ob_cnt)
  );

  assign bus.out_valid = ob_valid;
  assign bus.out_data  = ob_valid ? ob_head[DW-1:0] : '0;
  assign bus.out_src   = ob_valid & ob_head[DW];

  a_rvalid_tagged: assert property (
    @(posedge clk) disable iff (reset)
    core_rvalid |-> pipe_v[RD_LAT-1]
  );

endmodule

// File: tb/tb_mem_fifo_sched.sv
// Directed bench for mem_fifo_sched with a FIFO core stub.
// Each task drives one scenario and checks it inline.
module tb_mem_fifo_sched;
  import mem_sched_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_req;
  logic             flush_done;
  logic             core_wen;
  logic [15:0]      core_wdata;
  logic             core_ren;
  logic             core_flush;
  logic [15:0]      core_rdata;
  logic             core_rvalid;
  logic [OCC_W-1:0] occupancy;
  logic             almost_full;

  int total = 0;
  int bad   = 0;

  logic [16:0] got_q [$];
  logic [1:0]  gnt_q [$];
  int nflush;
  int ndone;

  mem_fifo_sched_if #(.DW(16)) bus ();

  mem_fifo_sched #(
    .DW(16), .DEPTH(64), .RD_LAT(1), .OBUF(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .core_wen    (core_wen),
    .core_wdata  (core_wdata),
    .core_ren    (core_ren),
    .core_flush  (core_flush),
    .core_rdata  (core_rdata),
    .core_rvalid (core_rvalid),
    .occupancy   (occupancy),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  // Memory core stub: FIFO with one-cycle read latency
  logic [15:0] cmem [64];
  logic [5:0]  cwp;
  logic [5:0]  crp;
  always @(posedge clk) begin
    if (reset || core_flush) begin
      cwp <= '0;
      crp <= '0;
      core_rvalid <= 1'b0;
      core_rdata <= '0;
    end else begin
      core_rvalid <= core_ren;
      if (core_wen) begin
        cmem[cwp] <= core_wdata;
        cwp <= cwp + 6'd1;
      end
      if (core_ren) begin
        core_rdata <= cmem[crp];
        crp <= crp + 6'd1;
      end
    end
  end

  // Mid-cycle monitor of outputs and grants
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready)
        got_q.push_back({bus.out_src, bus.out_data});
      if (core_wen) gnt_q.push_back(bus.in_ready);
      if (core_flush) nflush++;
      if (flush_done) ndone++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 2'b00;
    bus.out_ready = 1'b0;
    flush_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    got_q.delete();
    gnt_q.delete();
    nflush = 0;
    ndone = 0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (got_q.size() < n) begin
      bad++;
      $display("FAIL wait_out: got %0d words want %0d",
               got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if (occupancy !== 7'd0) begin
      bad++;
      $display("FAIL rst_occ: got %0d want 0", occupancy);
    end
    total++;
    if ({core_wen, core_ren, core_flush, flush_done,
         almost_full} !== 5'b0) begin
      bad++;
      $display("FAIL rst_strobes: got %b want 00000",
               {core_wen, core_ren, core_flush, flush_done,
                almost_full});
    end
    total++;
    if (bus.in_ready !== 2'b00) begin
      bad++;
      $display("FAIL rst_in_ready: got %b want 00", bus.in_ready);
    end
    bus.in_valid = 2'b11;
    #1;
    total++;
    if (bus.in_ready !== 2'b01) begin
      bad++;
      $display("FAIL rst_rr_ptr: got %b want 01", bus.in_ready);
    end
    bus.in_valid = 2'b00;
  endtask

  task automatic test_ch0();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 2'b01;
      bus.in_data0 = 16'hA1 + 16'(i);
      #1;
      total++;
      if (bus.in_ready !== 2'b01) begin
        bad++;
        $display("FAIL ch0_ready[%0d]: got %b want 01",
                 i, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 2'b00;
    wait_out(3, 30);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q[i] !== {1'b0, 16'hA1 + 16'(i)}) begin
        bad++;
        $display("FAIL ch0_data[%0d]: got %h want %h", i,
                 got_q[i], {1'b0, 16'hA1 + 16'(i)});
      end
    end
    total++;
    if (occupancy !== 7'd0) begin
      bad++;
      $display("FAIL ch0_occ: got %0d want 0", occupancy);
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_g [4];
    logic [16:0] exp_d [4];
    exp_g[0] = 2'b01; exp_d[0] = {1'b0, 16'hB0};
    exp_g[1] = 2'b10; exp_d[1] = {1'b1, 16'hC1};
    exp_g[2] = 2'b01; exp_d[2] = {1'b0, 16'hB2};
    exp_g[3] = 2'b10; exp_d[3] = {1'b1, 16'hC3};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 2'b11;
      bus.in_data0 = 16'hB0 + 16'(i);
      bus.in_data1 = 16'hC0 + 16'(i);
      tick();
    end
    bus.in_valid = 2'b00;
    wait_out(4, 30);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gnt_q[i] !== exp_g[i]) begin
        bad++;
        $display("FAIL alt_grant[%0d]: got %b want %b",
                 i, gnt_q[i], exp_g[i]);
      end
      total++;
      if (got_q[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL alt_data[%0d]: got %h want %h",
                 i, got_q[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 2'b01;
      bus.in_data0 = 16'(i);
      tick();
    end
    bus.in_valid = 2'b00;
    repeat (3) tick();
    total++;
    if (occupancy !== 7'd60) begin
      bad++;
      $display("FAIL fill_occ60: got %0d want 60", occupancy);
    end
    total++;
    if ({bus.out_valid, bus.out_src, bus.out_data, core_ren,
         almost_full} !== {2'b10, 16'h0, 2'b00}) begin
      bad++;
      $display("FAIL fill_obuf: got v%b s%b d%h r%b af%b",
               bus.out_valid, bus.out_src, bus.out_data,
               core_ren, almost_full);
    end
    bus.in_valid = 2'b01;
    bus.in_data0 = 16'd64;
    tick();
    total++;
    if ({occupancy, almost_full} !== {7'd61, 1'b0}) begin
      bad++;
      $display("FAIL fill_af61: got occ %0d af %b want 61 0",
               occupancy, almost_full);
    end
    bus.in_data0 = 16'd65;
    tick();
    total++;
    if ({occupancy, almost_full} !== {7'd62, 1'b1}) begin
      bad++;
      $display("FAIL fill_af62: got occ %0d af %b want 62 1",
               occupancy, almost_full);
    end
    bus.in_data0 = 16'd66;
    tick();
    bus.in_data0 = 16'd67;
    tick();
    bus.in_data0 = 16'd68;
    #1;
    total++;
    if ({bus.in_ready, core_wen} !== 3'b000) begin
      bad++;
      $display("FAIL fill_full_ready: got %b %b want 00 0",
               bus.in_ready, core_wen);
    end
    tick();
    tick();
    total++;
    if (occupancy !== 7'd64) begin
      bad++;
      $display("FAIL fill_occ64: got %0d want 64", occupancy);
    end
    bus.in_valid = 2'b00;
    bus.out_ready = 1'b1;
    wait_out(68, 300);
    for (int i = 0; i < 68; i++) begin
      total++;
      if (got_q[i] !== {1'b0, 16'(i)}) begin
        bad++;
        $display("FAIL fill_data[%0d]: got %h want %h",
                 i, got_q[i], {1'b0, 16'(i)});
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = 2'b10;
      bus.in_data1 = 16'h100 + 16'(i);
      tick();
    end
    bus.in_valid = 2'b00;
    repeat (3) tick();
    total++;
    if (occupancy !== 7'd10) begin
      bad++;
      $display("FAIL flush_occ10: got %0d want 10", occupancy);
    end
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    bus.in_valid = 2'b11;
    #1;
    total++;
    if (bus.in_ready !== 2'b00) begin
      bad++;
      $display("FAIL flush_drain_ready: got %b want 00",
               bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 120 && ndone == 0; k++) begin
      flush_req = (k == 2);
      tick();
    end
    flush_req = 1'b0;
    total++;
    if (ndone == 0) begin
      bad++;
      $display("FAIL flush_timeout: got no flush_done");
    end
    total++;
    if ({ndone, nflush} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL flush_pulses: got done %0d flush %0d want 1 1",
               ndone, nflush);
    end
    total++;
    if ({occupancy, bus.in_ready} !== {7'd0, 2'b01}) begin
      bad++;
      $display("FAIL flush_run: got occ %0d rdy %b want 0 01",
               occupancy, bus.in_ready);
    end
    bus.in_valid = 2'b00;
    total++;
    if (got_q.size() != 14) begin
      bad++;
      $display("FAIL flush_count: got %0d want 14", got_q.size());
    end
    for (int i = 0; i < 14; i++) begin
      total++;
      if (got_q[i] !== {1'b1, 16'h100 + 16'(i)}) begin
        bad++;
        $display("FAIL flush_data[%0d]: got %h want %h", i,
                 got_q[i], {1'b1, 16'h100 + 16'(i)});
      end
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 2'b01;
      bus.in_data0 = 16'h50 + 16'(i);
      tick();
    end
    bus.in_valid = 2'b00;
    repeat (3) tick();
    total++;
    if (occupancy !== 7'd5) begin
      bad++;
      $display("FAIL sim_occ_pre: got %0d want 5", occupancy);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 2'b01;
    bus.in_data0 = 16'h59;
    #1;
    total++;
    if ({core_wen, core_ren} !== 2'b11) begin
      bad++;
      $display("FAIL sim_both: got wen %b ren %b want 1 1",
               core_wen, core_ren);
    end
    tick();
    bus.in_valid = 2'b00;
    total++;
    if (occupancy !== 7'd5) begin
      bad++;
      $display("FAIL sim_occ_post: got %0d want 5", occupancy);
    end
    bus.out_ready = 1'b1;
    wait_out(10, 40);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (got_q[i] !== {1'b0, 16'h50 + 16'(i)}) begin
        bad++;
        $display("FAIL sim_data[%0d]: got %h want %h", i,
                 got_q[i], {1'b0, 16'h50 + 16'(i)});
      end
    end
  endtask

  task automatic test_wrap();
    logic        src;
    logic [16:0] exp;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      src = 1'((i / 5) % 2);
      bus.in_valid = src ? 2'b10 : 2'b01;
      bus.in_data0 = 16'h2000 + 16'(i);
      bus.in_data1 = 16'h3000 + 16'(i);
      tick();
    end
    bus.in_valid = 2'b00;
    wait_out(80, 100);
    for (int i = 0; i < 80; i++) begin
      src = 1'((i / 5) % 2);
      exp = {src, (src ? 16'h3000 : 16'h2000) + 16'(i)};
      total++;
      if (got_q[i] !== exp) begin
        bad++;
        $display("FAIL wrap_data[%0d]: got %h want %h",
                 i, got_q[i], exp);
      end
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 2'b01;
      bus.in_data0 = 16'h60 + 16'(i);
      tick();
    end
    bus.in_valid = 2'b00;
    reset = 1'b1;
    tick();
    total++;
    if ({bus.out_valid, occupancy} !== {1'b0, 7'd0}) begin
      bad++;
      $display("FAIL rif_state: got v %b occ %0d want 0 0",
               bus.out_valid, occupancy);
    end
    reset = 1'b0;
    got_q.delete();
    bus.in_valid = 2'b01;
    bus.in_data0 = 16'h77;
    #1;
    total++;
    if (bus.in_ready !== 2'b01) begin
      bad++;
      $display("FAIL rif_run: got %b want 01", bus.in_ready);
    end
    tick();
    bus.in_valid = 2'b00;
    bus.out_ready = 1'b1;
    wait_out(1, 20);
    repeat (5) tick();
    total++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 16'h77}) begin
      bad++;
      $display("FAIL rif_data: got n %0d d %h want 1 %h",
               got_q.size(), got_q[0], {1'b0, 16'h77});
    end
  endtask

  initial begin
    reset = 1'b1;
    flush_req = 1'b0;
    bus.in_valid = 2'b00;
    bus.in_data0 = '0;
    bus.in_data1 = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ch0();
    test_alternate();
    test_fill();
    test_flush();
    test_simul();
    test_wrap();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
